psum_rd_seq: RTL
================

# psum_rd_seq

Read-out sequencer for the partial-sum SRAM banks. On a start pulse it walks a block of psum rows across all `PE_COL` banks. Each cycle it issues exactly one one-hot bank read enable plus a row address, and flags the beat valid. The banks' gated outputs then drive the OR-combined write-back stage, one psum per beat. This block is the initiator that produces the `Psram_En` / `Valid_WB_Psum` stream the write-back stage consumes.

## Interface
Parameters:
- `N_BANK`, default `` `PE_COL `` (32), number of psum banks; `o_Psram_En` width.
- `ADDR_W`, default 8, psum SRAM row-address width.

Ports:
- `CLK` in 1: single clock; everything is on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `i_Start` in 1: start request, sampled only in IDLE.
- `i_Base_Addr` in `ADDR_W`: first row address, latched on an accepted start.
- `i_Num_Rows` in `ADDR_W+1`: rows to read per bank, 0..2^ADDR_W, latched on an accepted start.
- `i_Stall` in 1: downstream backpressure; a stalled cycle issues no beat.
- `o_Psram_En` out `N_BANK`: one-hot bank read enable, or all-zero.
- `o_Psram_Addr` out `ADDR_W`: row address of the current beat.
- `o_Valid_WB_Psum` out 1: beat valid; equals `|o_Psram_En`.
- `o_Busy` out 1: high in RUN and DONE.
- `o_Done` out 1: one-cycle pulse at the end of a block.

## Operation
- States: IDLE, RUN, DONE. Internal registers: `bank` (log2 N_BANK), `row` (ADDR_W+1), `addr` (ADDR_W), `num_rows`.
- IDLE, start sampled with `i_Start=1`:
  - Latch `num_rows` and `addr=i_Base_Addr`; clear `bank` and `row`.
  - Next state is RUN if `i_Num_Rows!=0`, otherwise DONE.
- RUN, beat issue:
  - A beat is issued when `i_Stall=0`.
  - `o_Psram_En = 1<<bank`, `o_Psram_Addr = addr`, `o_Valid_WB_Psum = 1`.
  - These outputs are combinational from the state registers and `i_Stall`.
- RUN, stalled cycle (`i_Stall=1`): `o_Psram_En=0`, `o_Valid_WB_Psum=0`, `o_Psram_Addr` holds, counters hold.
- Beat order: bank index is the inner loop and row is the outer loop. Per row, banks go 0..N_BANK-1, then `addr+1` and `row+1`.
- Block size: total beats = `num_rows*N_BANK`, with no gaps except stalls.
- Address arithmetic: `addr` increments modulo 2^ADDR_W; wrap-around is legal and silent.
- Last beat: issued beat with `bank==N_BANK-1 && row==num_rows-1`; next state is DONE.
- DONE: `o_Done=1` for exactly one cycle, no beat; next state IDLE. `i_Stall` is ignored here.
- Start while not IDLE: ignored entirely; latched values are unchanged.
- Parameter changes after acceptance have no effect.
- Outputs in IDLE: `o_Psram_En=0`, `o_Valid_WB_Psum=0`, `o_Busy=0`, `o_Done=0`.

## Timing
- Reset effect: at an edge with `RST=1`, the state goes to IDLE and all counters clear. From that cycle on, all outputs are 0, `o_Psram_Addr` included.
- Reset mid-RUN aborts the block with no Done pulse.
- `RST` has priority over `i_Start` at the same edge.
- Start latency: start sampled at edge k puts the first beat in cycle k+1, provided `i_Stall=0`.
- Block timing, no stalls: beat j occupies cycle k+1+j; `o_Done` is in cycle k+1+num_rows*N_BANK.
- Stall timing: each stalled RUN cycle adds exactly one cycle.
- `i_Num_Rows=0`: `o_Done` in cycle k+1 and no beats.
- Back-to-back blocks: earliest next accepted start is at the edge ending the IDLE cycle after DONE.
- Downstream contract: bank data arrives 1 cycle after its enable. The write-back stage realigns that data with its 2-cycle valid delay, so this block adds no extra valid delay.

## Structure
- Shared include `param.v` supplies `PE_COL` and `BIT_PSUM`.
- Add `` `PSUM_ADDR_W `` and the state encodings `` `PRS_IDLE/RUN/DONE `` to `param.v`.
- One sub-module is natural: `onehot_dec` (log2 N_BANK → N_BANK one-hot, with an enable input). It is also reusable by the psum write path.
- Remaining logic: FSM plus three counters, about 150–200 lines.

## Test plan
- Reset: hold `RST` 3 cycles with random inputs → all outputs 0; `i_Start` in the reset cycle is ignored.
- Single row: base=0x10, rows=1, no stall → 32 beats with `o_Psram_En` = 1,2,4…0x8000_0000, addr=0x10 throughout. `o_Done` lands 33 cycles after the start cycle; `o_Busy` is high for 33 cycles.
- Stalls: rows=3 with `i_Stall` high during beats 5–8 (4 cycles) → 96 valid beats with an unchanged sequence, no en/valid during the stall, `o_Done` 4 cycles later than the unstalled run.
- Wrap: base=0xFE, rows=3 → addr sequence 0xFE×32, 0xFF×32, 0x00×32.
- Zero rows: rows=0 → no valid beats, `o_Done` in the cycle after start. A start pulse asserted during RUN of another block is ignored, and that block's beat count stays exact.
- Abort: `RST` at beat 40 of a rows=2 block → en=0 the next cycle, no Done pulse. A new start (base=0x20, rows=1) then runs cleanly from bank 0, addr 0x20.

Source files
------------

// File: rtl/psum_rd_seq_pkg.sv
// Shared definitions for the partial-sum read-out sequencer.
// Bank count, address width and FSM state encoding.
package psum_rd_seq_pkg;

    localparam int PE_COL      = 32;
    localparam int BIT_PSUM    = 32;
    localparam int PSUM_ADDR_W = 8;

    typedef enum logic [1:0] {
        PRS_IDLE = 2'd0,
        PRS_RUN  = 2'd1,
        PRS_DONE = 2'd2
    } prs_state_e;

endpackage

// File: rtl/psum_rd_seq_onehot_dec.sv
// Binary index to one-hot decoder with enable; all-zero when disabled.
// Also usable by the psum write path.
module onehot_dec #(
    parameter int N = 32,
    parameter int W = $clog2(N)
) (
    input  logic [W-1:0] idx_i,
    input  logic         en_i,
    output logic [N-1:0] oh_o
);

    always_comb begin
        oh_o = '0;
        for (int i = 0; i < N; i++) begin
            oh_o[i] = en_i && (idx_i == W'(i));
        end
    end

endmodule

// File: rtl/psum_rd_seq.sv
// Walks a block of psum rows across all banks, one one-hot bank read
// per beat, bank as the inner loop and row as the outer loop.
module psum_rd_seq
    import psum_rd_seq_pkg::*;
#(
    parameter int N_BANK = PE_COL,
    parameter int ADDR_W = PSUM_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_Start,
    input  logic [ADDR_W-1:0] i_Base_Addr,
    input  logic [ADDR_W:0]   i_Num_Rows,
    input  logic              i_Stall,
    output logic [N_BANK-1:0] o_Psram_En,
    output logic [ADDR_W-1:0] o_Psram_Addr,
    output logic              o_Valid_WB_Psum,
    output logic              o_Busy,
    output logic              o_Done
);

    localparam int BW    = $clog2(N_BANK);
    localparam int ROW_W = ADDR_W + 1;

    prs_state_e        state_q, state_d;
    logic [BW-1:0]     bank_q, bank_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ROW_W-1:0]  nrows_q, nrows_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              beat;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= PRS_IDLE;
            bank_q  <= '0;
            row_q   <= '0;
            nrows_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            nrows_q <= nrows_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        row_d   = row_q;
        nrows_d = nrows_q;
        addr_d  = addr_q;
        beat    = 1'b0;
        o_Busy  = 1'b0;
        o_Done  = 1'b0;
        unique case (state_q)
            PRS_IDLE: begin
                if (i_Start) begin
                    nrows_d = i_Num_Rows;
                    addr_d  = i_Base_Addr;
                    bank_d  = '0;
                    row_d   = '0;
                    state_d = (i_Num_Rows != '0) ? PRS_RUN : PRS_DONE;
                end
            end
            PRS_RUN: begin
                o_Busy = 1'b1;
                beat   = !i_Stall;
                if (beat) begin
                    if (bank_q == BW'(N_BANK - 1)) begin
                        bank_d = '0;
                        row_d  = row_q + ROW_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                        if (row_q == nrows_q - ROW_W'(1)) begin
                            state_d = PRS_DONE;
                        end
                    end else begin
                        bank_d = bank_q + BW'(1);
                    end
                end
            end
            PRS_DONE: begin
                o_Busy  = 1'b1;
                o_Done  = 1'b1;
                state_d = PRS_IDLE;
            end
            default: state_d = PRS_IDLE;
        endcase
    end

    onehot_dec #(
        .N (N_BANK),
        .W (BW)
    ) u_dec (
        .idx_i (bank_q),
        .en_i  (beat),
        .oh_o  (o_Psram_En)
    );

    assign o_Psram_Addr    = addr_q;
    assign o_Valid_WB_Psum = beat;

endmodule
